sdram_arbiter_2p: RTL and testbench

// - Shares the single SdramCtrl request port between two requesters (A, B) with round-robin arbitration.
// - Holds all grants off for the 400 us SDRAM power-up wait, then serialises one access at a time.
// - Routes each ack and read word back to the requester that issued the access.
// - Sits between user logic (test FSMs, DMA) and SdramCtrl; the wait counter is moved here out of the top.

---
 rtl/sdram_arb_pkg.sv | 27 ++
 rtl/sdram_init_timer.sv | 39 +++
 rtl/sdram_arbiter_2p.sv | 161 ++++++++++++++++
 tb/tb_sdram_arbiter_2p.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizing for the two-port SDRAM arbiter.
// State encodings are one-hot; grant tracking drives the round-robin tie-break.
package sdram_arb_pkg;

  localparam int ADDR_W_DEF      = 24;
  localparam int DATA_W_DEF      = 16;
  localparam int INIT_WAIT_DEF   = 25000;
  localparam int ACK_TIMEOUT_DEF = 1024;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_DONE  = 4'b1000
  } state_e;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  // B wins when it is the only requester, or on a tie when A was served last.
  function automatic logic pick_b(input logic req_a, input logic req_b, input grant_e last);
    return req_b && (!req_a || (last == GRANT_A));
  endfunction

endpackage

// File: rtl/sdram_init_timer.sv
// Saturating power-up counter; ready rises the cycle after the count
// reaches INIT_WAIT-1 and stays high until the next reset.
module sdram_init_timer
  import sdram_arb_pkg::*;
#(
  parameter int INIT_WAIT = INIT_WAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic ready
);

  localparam int CNT_W = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_WAIT - 1);

  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic             ready_q, ready_d;

  always_comb begin
    init_cnt_d = init_cnt_q;
    if (init_cnt_q != CNT_LAST) begin
      init_cnt_d = init_cnt_q + 1'b1;
    end
    ready_d = (init_cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      init_cnt_q <= init_cnt_d;
      ready_q    <= ready_d;
    end
  end

  assign ready = ready_q;

endmodule

// File: rtl/sdram_arbiter_2p.sv
// Round-robin arbiter sharing one SdramCtrl request port between requesters A and B,
// with power-up hold-off, per-access ack timeout and ack/read-data routing.
module sdram_arbiter_2p
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int INIT_WAIT   = INIT_WAIT_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_rh_wl,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data_w,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_data_r,
  input  logic              b_req,
  input  logic              b_rh_wl,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data_w,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_data_r,
  output logic              sdram_req,
  output logic              sdram_rh_wl,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_data_w,
  input  logic              sdram_ack,
  input  logic [DATA_W-1:0] sdram_data_r,
  output logic              ready,
  output logic              timeout_err,
  output logic              busy_b
);

  localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              sdram_req_q, sdram_req_d;
  logic              sdram_rh_wl_q, sdram_rh_wl_d;
  logic [ADDR_W-1:0] sdram_addr_q, sdram_addr_d;
  logic [DATA_W-1:0] sdram_data_w_q, sdram_data_w_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic [DATA_W-1:0] a_data_r_q, a_data_r_d;
  logic [DATA_W-1:0] b_data_r_q, b_data_r_d;
  logic              timeout_err_q, timeout_err_d;
  logic              busy_b_q, busy_b_d;
  logic              grant_b;

  sdram_init_timer #(
    .INIT_WAIT(INIT_WAIT)
  ) u_init_timer (
    .clk  (clk),
    .reset(reset),
    .ready(ready)
  );

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    wait_cnt_d     = wait_cnt_q;
    sdram_req_d    = 1'b0;
    sdram_rh_wl_d  = sdram_rh_wl_q;
    sdram_addr_d   = sdram_addr_q;
    sdram_data_w_d = sdram_data_w_q;
    a_ack_d        = 1'b0;
    b_ack_d        = 1'b0;
    a_data_r_d     = a_data_r_q;
    b_data_r_d     = b_data_r_q;
    timeout_err_d  = timeout_err_q;
    busy_b_d       = busy_b_q;
    grant_b        = pick_b(a_req, b_req, last_grant_q);

    unique case (state_q)
      ST_IDLE: begin
        if (ready && (a_req || b_req)) begin
          state_d        = ST_ISSUE;
          sdram_req_d    = 1'b1;
          last_grant_d   = grant_b ? GRANT_B : GRANT_A;
          busy_b_d       = grant_b;
          sdram_rh_wl_d  = grant_b ? b_rh_wl : a_rh_wl;
          sdram_addr_d   = grant_b ? b_addr : a_addr;
          sdram_data_w_d = grant_b ? b_data_w : a_data_w;
        end
      end
      ST_ISSUE: begin
        state_d    = ST_WAIT;
        wait_cnt_d = '0;
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        // An ack in the final wait cycle still counts as a normal completion.
        if (sdram_ack || (wait_cnt_q == WAIT_LAST)) begin
          state_d = ST_DONE;
          a_ack_d = (last_grant_q == GRANT_A);
          b_ack_d = (last_grant_q == GRANT_B);
          if (!sdram_ack) begin
            timeout_err_d = 1'b1;
          end else if (sdram_rh_wl_q) begin
            if (last_grant_q == GRANT_B) b_data_r_d = sdram_data_r;
            else                         a_data_r_d = sdram_data_r;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= GRANT_B;
      wait_cnt_q     <= '0;
      sdram_req_q    <= 1'b0;
      sdram_rh_wl_q  <= 1'b1;
      sdram_addr_q   <= '0;
      sdram_data_w_q <= '0;
      a_ack_q        <= 1'b0;
      b_ack_q        <= 1'b0;
      a_data_r_q     <= '0;
      b_data_r_q     <= '0;
      timeout_err_q  <= 1'b0;
      busy_b_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      wait_cnt_q     <= wait_cnt_d;
      sdram_req_q    <= sdram_req_d;
      sdram_rh_wl_q  <= sdram_rh_wl_d;
      sdram_addr_q   <= sdram_addr_d;
      sdram_data_w_q <= sdram_data_w_d;
      a_ack_q        <= a_ack_d;
      b_ack_q        <= b_ack_d;
      a_data_r_q     <= a_data_r_d;
      b_data_r_q     <= b_data_r_d;
      timeout_err_q  <= timeout_err_d;
      busy_b_q       <= busy_b_d;
    end
  end

  assign sdram_req    = sdram_req_q;
  assign sdram_rh_wl  = sdram_rh_wl_q;
  assign sdram_addr   = sdram_addr_q;
  assign sdram_data_w = sdram_data_w_q;
  assign a_ack        = a_ack_q;
  assign b_ack        = b_ack_q;
  assign a_data_r     = a_data_r_q;
  assign b_data_r     = b_data_r_q;
  assign timeout_err  = timeout_err_q;
  assign busy_b       = busy_b_q;

endmodule

// File: tb/tb_sdram_arbiter_2p.sv
// Directed bench for sdram_arbiter_2p: power-up hold-off, reads/writes, round-robin,
// ack timeout, spurious acks and reset mid-access, against a small controller model.
module tb_sdram_arbiter_2p;

  localparam int ADDR_W      = 24;
  localparam int DATA_W      = 16;
  localparam int INIT_WAIT   = 100;
  localparam int ACK_TIMEOUT = 8;

  typedef struct {
    logic              rh_wl;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } acc_t;

  typedef struct {
    int                cyc;
    logic              rh_wl;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;
  } req_t;

  typedef struct {
    int                cyc;
    logic              is_b;
    logic [ADDR_W-1:0] addr_at;
  } ack_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              a_req = 1'b0, a_rh_wl = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0;
  logic [DATA_W-1:0] a_data_w = '0;
  logic              a_ack;
  logic [DATA_W-1:0] a_data_r;
  logic              b_req = 1'b0, b_rh_wl = 1'b0;
  logic [ADDR_W-1:0] b_addr = '0;
  logic [DATA_W-1:0] b_data_w = '0;
  logic              b_ack;
  logic [DATA_W-1:0] b_data_r;
  logic              sdram_req, sdram_rh_wl;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_data_w;
  logic              sdram_ack = 1'b0;
  logic [DATA_W-1:0] sdram_data_r = '0;
  logic              ready, timeout_err, busy_b;

  // Bench-side controller model, requester queues and event logs
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  acc_t              a_q[$], b_q[$];
  req_t              req_log[$];
  ack_t              ack_log[$];
  int                cyc = 0;
  int                ack_at = -1;
  int                ctrl_delay = 5;
  logic              ctrl_mute = 1'b0;
  logic [DATA_W-1:0] ack_data = '0;
  logic              spur = 1'b0;
  logic [DATA_W-1:0] spur_data = '0;
  logic              a_ack_prev = 1'b0, b_ack_prev = 1'b0;
  int                checks = 0;
  int                errors = 0;

  sdram_arbiter_2p #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_WAIT(INIT_WAIT), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_rh_wl(a_rh_wl), .a_addr(a_addr), .a_data_w(a_data_w),
    .a_ack(a_ack), .a_data_r(a_data_r),
    .b_req(b_req), .b_rh_wl(b_rh_wl), .b_addr(b_addr), .b_data_w(b_data_w),
    .b_ack(b_ack), .b_data_r(b_data_r),
    .sdram_req(sdram_req), .sdram_rh_wl(sdram_rh_wl), .sdram_addr(sdram_addr),
    .sdram_data_w(sdram_data_w), .sdram_ack(sdram_ack), .sdram_data_r(sdram_data_r),
    .ready(ready), .timeout_err(timeout_err), .busy_b(busy_b)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Queue one access for a requester; it is presented on the next tick.
  task automatic applyStimulus(input logic is_b, input logic rh_wl, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data);
    acc_t t;
    t.rh_wl = rh_wl;
    t.addr  = addr;
    t.data  = data;
    if (is_b) b_q.push_back(t);
    else      a_q.push_back(t);
  endtask

  // One clock: controller model, logging, and requester updates, all #1 after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (reset) ack_at = -1;
    sdram_ack = 1'b0;
    if (spur) begin
      sdram_ack    = 1'b1;
      sdram_data_r = spur_data;
      spur         = 1'b0;
    end else if (ack_at == cyc && !ctrl_mute) begin
      sdram_ack    = 1'b1;
      sdram_data_r = ack_data;
    end
    if (sdram_req) begin
      req_log.push_back('{cyc, sdram_rh_wl, sdram_addr, sdram_data_w, busy_b});
      ack_at = cyc + ctrl_delay;
      if (sdram_rh_wl) ack_data = mem.exists(sdram_addr) ? mem[sdram_addr] : '0;
      else             mem[sdram_addr] = sdram_data_w;
    end
    if (a_ack) ack_log.push_back('{cyc, 1'b0, sdram_addr});
    if (b_ack) ack_log.push_back('{cyc, 1'b1, sdram_addr});
    if (a_ack_prev && a_q.size() > 0) void'(a_q.pop_front());
    if (b_ack_prev && b_q.size() > 0) void'(b_q.pop_front());
    a_ack_prev = a_ack;
    b_ack_prev = b_ack;
    a_req = (a_q.size() > 0);
    if (a_req) begin
      a_rh_wl = a_q[0].rh_wl; a_addr = a_q[0].addr; a_data_w = a_q[0].data;
    end
    b_req = (b_q.size() > 0);
    if (b_req) begin
      b_rh_wl = b_q[0].rh_wl; b_addr = b_q[0].addr; b_data_w = b_q[0].data;
    end
  endtask

  task automatic waitAcks(input int n, input int budget);
    int k = 0;
    while (ack_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    checkOutput("ack_count", ack_log.size(), n);
  endtask

  task automatic clearLogs();
    req_log.delete();
    ack_log.delete();
  endtask

  // Main directed sequence
  initial begin
    logic [ADDR_W-1:0] tie_addr [4];
    logic [DATA_W-1:0] tie_data [4];
    int k;

    // Power-up: A already requesting a write while reset is held
    applyStimulus(1'b0, 1'b0, 24'h000020, 16'hAAAA);
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    cyc = 0;
    clearLogs();
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_sdram_req", sdram_req, 0);
    checkOutput("rst_sdram_rh_wl", sdram_rh_wl, 1);
    checkOutput("rst_a_ack", a_ack, 0);
    checkOutput("rst_b_ack", b_ack, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    checkOutput("rst_busy_b", busy_b, 0);
    checkOutput("rst_a_data_r", a_data_r, 0);
    checkOutput("rst_sdram_addr", sdram_addr, 0);
    while (cyc < 99) tick();
    checkOutput("pwr_ready_c99", ready, 0);
    tick();
    checkOutput("pwr_ready_c100", ready, 1);
    checkOutput("pwr_no_req_c100", req_log.size(), 0);
    tick();
    checkOutput("pwr_req_c101", sdram_req, 1);
    waitAcks(1, 50);
    repeat (4) tick();
    checkOutput("pwr_one_pulse", req_log.size(), 1);
    if (ack_log.size() > 0) checkOutput("pwr_ack_cyc", ack_log[0].cyc, 107);
    checkOutput("pwr_write_data_r", a_data_r, 0);

    // Single read by A
    clearLogs();
    mem[24'h000010] = 16'hF055;
    applyStimulus(1'b0, 1'b1, 24'h000010, 16'h0000);
    waitAcks(1, 50);
    repeat (2) tick();
    checkOutput("rd_ack_cnt", ack_log.size(), 1);
    if (ack_log.size() > 0 && req_log.size() > 0) begin
      checkOutput("rd_is_a", ack_log[0].is_b, 0);
      checkOutput("rd_latency", ack_log[0].cyc - req_log[0].cyc, 6);
      checkOutput("rd_addr_hold", ack_log[0].addr_at, 24'h000010);
    end
    checkOutput("rd_a_data_r", a_data_r, 16'hF055);
    checkOutput("rd_b_data_r", b_data_r, 0);

    // B writes then reads back
    clearLogs();
    applyStimulus(1'b1, 1'b0, 24'h0ABCDE, 16'h1234);
    applyStimulus(1'b1, 1'b1, 24'h0ABCDE, 16'h0000);
    waitAcks(1, 50);
    checkOutput("wr_b_data_r_before", b_data_r, 0);
    waitAcks(2, 50);
    tick();
    checkOutput("wr_b_data_r_after", b_data_r, 16'h1234);
    if (req_log.size() >= 2) begin
      checkOutput("wr_rh_wl_0", req_log[0].rh_wl, 0);
      checkOutput("wr_rh_wl_1", req_log[1].rh_wl, 1);
      checkOutput("wr_addr_0", req_log[0].addr, 24'h0ABCDE);
      checkOutput("wr_addr_1", req_log[1].addr, 24'h0ABCDE);
      checkOutput("wr_data_w", req_log[0].data, 16'h1234);
    end
    checkOutput("wr_a_data_r", a_data_r, 16'hF055);

    // Tie: both requesters continuously active for two accesses each
    clearLogs();
    tie_addr = '{24'h000100, 24'h000200, 24'h000101, 24'h000201};
    tie_data = '{16'h1111, 16'h3333, 16'h2222, 16'h4444};
    applyStimulus(1'b0, 1'b0, tie_addr[0], tie_data[0]);
    applyStimulus(1'b0, 1'b0, tie_addr[2], tie_data[2]);
    applyStimulus(1'b1, 1'b0, tie_addr[1], tie_data[1]);
    applyStimulus(1'b1, 1'b0, tie_addr[3], tie_data[3]);
    waitAcks(4, 100);
    for (int i = 0; i < 4; i++) begin
      if (i < req_log.size() && i < ack_log.size()) begin
        checkOutput($sformatf("tie_busy_b_%0d", i), req_log[i].busy, i % 2);
        checkOutput($sformatf("tie_addr_%0d", i), req_log[i].addr, tie_addr[i]);
        checkOutput($sformatf("tie_data_%0d", i), req_log[i].data, tie_data[i]);
        checkOutput($sformatf("tie_ack_b_%0d", i), ack_log[i].is_b, i % 2);
        checkOutput($sformatf("tie_addr_hold_%0d", i), ack_log[i].addr_at, tie_addr[i]);
      end
    end

    // Ack in the last wait cycle wins over the timeout
    clearLogs();
    ctrl_delay = 8;
    mem[24'h000040] = 16'hBEEF;
    applyStimulus(1'b0, 1'b1, 24'h000040, 16'h0000);
    waitAcks(1, 50);
    if (ack_log.size() > 0 && req_log.size() > 0)
      checkOutput("edge_latency", ack_log[0].cyc - req_log[0].cyc, 9);
    checkOutput("edge_no_timeout", timeout_err, 0);
    checkOutput("edge_a_data_r", a_data_r, 16'hBEEF);

    // Timeout: controller never acks
    clearLogs();
    ctrl_mute = 1'b1;
    applyStimulus(1'b0, 1'b1, 24'h000030, 16'h0000);
    waitAcks(1, 50);
    if (ack_log.size() > 0 && req_log.size() > 0) begin
      checkOutput("to_latency", ack_log[0].cyc - req_log[0].cyc, 9);
      checkOutput("to_is_a", ack_log[0].is_b, 0);
      checkOutput("to_addr_hold", ack_log[0].addr_at, 24'h000030);
    end
    checkOutput("to_err_set", timeout_err, 1);
    checkOutput("to_a_data_r", a_data_r, 16'hBEEF);
    repeat (3) tick();
    checkOutput("to_err_sticky", timeout_err, 1);
    spur = 1'b1;
    spur_data = 16'hDEAD;
    repeat (3) tick();
    checkOutput("late_ack_no_xack", ack_log.size(), 1);
    checkOutput("late_ack_a_data_r", a_data_r, 16'hBEEF);
    checkOutput("late_ack_b_data_r", b_data_r, 16'h1234);
    ctrl_mute = 1'b0;
    ctrl_delay = 5;

    // Reset while the access sits in WAIT
    clearLogs();
    mem[24'h000050] = 16'h5A5A;
    applyStimulus(1'b1, 1'b1, 24'h000050, 16'h0000);
    k = 0;
    while (req_log.size() == 0 && k < 20) begin
      tick();
      k++;
    end
    checkOutput("mid_req_seen", req_log.size(), 1);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc = 0;
    checkOutput("mid_sdram_req", sdram_req, 0);
    checkOutput("mid_b_ack", b_ack, 0);
    checkOutput("mid_ready", ready, 0);
    checkOutput("mid_busy_b", busy_b, 0);
    checkOutput("mid_timeout_clr", timeout_err, 0);
    while (cyc < 100) tick();
    checkOutput("mid_no_ack", ack_log.size(), 0);
    checkOutput("mid_no_early_req", req_log.size(), 1);
    waitAcks(1, 50);
    if (req_log.size() >= 2) checkOutput("mid_regrant_cyc", req_log[1].cyc, 101);
    if (ack_log.size() > 0) checkOutput("mid_ack_is_b", ack_log[0].is_b, 1);
    tick();
    checkOutput("mid_b_data_r", b_data_r, 16'h5A5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
